bram_fifo_reader: RTL and testbench
===================================

# bram_fifo_reader

Read-side adapter for `bram_fifo`. It pops words from the FIFO, absorbs the FIFO's fixed read latency, and presents the data as a valid/ready stream with no bubbles and no lost words under arbitrary downstream backpressure. It sits between the BRAM FIFO read port and any downstream consumer, e.g. a packetizer or a DMA.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; must match the connected `bram_fifo`.
- `READ_LATENCY`, 2: cycles from the edge that samples `FIFO_RD_EN=1` with `FIFO_EMPTY=0` to the edge where `FIFO_DOUT` holds that word. Legal range 1..4.
- `SKID_DEPTH`, `READ_LATENCY+1`: entries in the internal output buffer. Must be ≥ `READ_LATENCY+1`.

Ports:
- `CLK` in 1: single clock for everything.
- `RESET` in 1: synchronous, active-high.
- `FIFO_DOUT` in `DATA_WIDTH`: `bram_fifo` DOUT.
- `FIFO_EMPTY` in 1: `bram_fifo` EMPTY. Registered; reflects every pop sampled up to the previous edge.
- `FIFO_ALMOST_EMPTY` in 1: `bram_fifo` ALMOST_EMPTY. Status only; not used for issue.
- `FIFO_RD_EN` out 1: pop request to `bram_fifo`.
- `M_DATA` out `DATA_WIDTH`: stream data.
- `M_VALID` out 1: stream valid.
- `M_READY` in 1: stream ready from the consumer.
- `OCCUPANCY` out `$clog2(SKID_DEPTH+1)`: words currently held in the skid buffer.

## Operation
- **Issue rule:** `FIFO_RD_EN = !RESET && !FIFO_EMPTY && (inflight + occupancy + pop_this_cycle_credit) < SKID_DEPTH`.
  - Combinational from registered state and `FIFO_EMPTY`.
  - A sampled `FIFO_RD_EN=1` with `FIFO_EMPTY=1` is never generated.
- **In-flight tracking:** shift register `rd_pipe[READ_LATENCY]`. A 1 enters at each issued pop. When the 1 exits the last stage, `FIFO_DOUT` is captured into the skid buffer on that edge.
- **inflight:** the number of ones in `rd_pipe`. Implement it as a counter, not a popcount. The counter increments on issue, decrements on capture, and both may happen in the same cycle.
- **Skid buffer:** register FIFO of `SKID_DEPTH` entries, first-word fall-through.
  - `M_VALID = occupancy != 0`.
  - `M_DATA` is the head entry.
  - A transfer occurs on any edge where `M_VALID && M_READY`.
- **Credit accounting:** a transfer in the current cycle frees one slot for issue in that same cycle (`pop_this_cycle_credit` = -1 when transferring). The invariant `inflight + occupancy ≤ SKID_DEPTH` holds at every edge.
- **Ordering:** words appear on `M_DATA` in exactly FIFO order. No duplication, no drops.
- **Wrap-around:** the skid read and write pointers wrap modulo `SKID_DEPTH`. `SKID_DEPTH` need not be a power of 2.
- **Simultaneous capture and transfer with occupancy = `SKID_DEPTH`:** cannot occur, because the credit rule forbids it. Assertion required.
- **Reset:**
  - Clears `rd_pipe`, the inflight counter, the skid pointers, and `occupancy`.
  - Words already popped from the FIFO but not delivered are discarded.
  - The reset is expected to be applied together with the FIFO reset.

## Timing
- **Reset values:** `FIFO_RD_EN=0`, `M_VALID=0`, `M_DATA=0`, `OCCUPANCY=0`.
- **Latency:** from the first issuing edge to `M_VALID=1` is `READ_LATENCY` edges.
  - With the FIFO non-empty and `M_READY` held 1, throughput is 1 word/cycle after the initial latency.
- **Backpressure:**
  - When `M_READY` drops, issue stops once `inflight + occupancy` reaches `SKID_DEPTH`.
  - All in-flight words land in the buffer.
  - When `M_READY` returns, the stream resumes the next cycle with no bubble.
- `M_DATA` and `M_VALID` are stable while `M_VALID && !M_READY`.

## Structure
- **Shared package `bram_fifo_pkg`:**
  - `DEFAULT_DATA_WIDTH`
  - `DEFAULT_READ_LATENCY`
  - a `clog2`-based width function for the occupancy and inflight counters
- **Sub-module `reader_skid_fifo`:** register FIFO (FWFT) with push, pop, data, count. Instantiated once.
- **Top level:** issue logic, `rd_pipe`, inflight counter.

## Test plan
Each scenario connects a real `bram_fifo` (`PTR_WIDTH=8`, `READ_LATENCY=2`), preloaded with values 0..255 unless stated.
- **Continuous drain:** `M_READY=1` throughout → values 0..255 on consecutive cycles; first `M_VALID` 2 edges after the first `FIFO_RD_EN`; `FIFO_EMPTY=1` and `OCCUPANCY=0` at the end.
- **Empty FIFO:** after reset, `M_READY=1` for 300 cycles → `FIFO_RD_EN` never 1, `M_VALID` never 1, FIFO read pointer unchanged.
- **Backpressure:** `M_READY=0` for 20 cycles, then 1 → exactly 3 pops issued, `OCCUPANCY=3`, `M_DATA=0` held stable; stream then continues 0..255 without gap or duplicate.
- **Random ready:** `M_READY` random at 30% duty, concurrent random FIFO writes of an incrementing sequence → output sequence identical to the input; assertions `inflight+occupancy≤3` and no issue while `FIFO_EMPTY` never fire.
- **Reset mid-stream:** `RESET` pulsed for 5 cycles at word 100, with 2 words in flight and 1 buffered, together with the FIFO reset → all outputs return to reset values next edge; after refill with 0..9, output is exactly 0..9.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the BRAM FIFO read-side adapter.
package bram_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH   = 32;
  localparam int unsigned DEFAULT_READ_LATENCY = 2;

  // Bits needed to hold any count in 0..max_val (never narrower than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reader_skid_fifo.sv
// First-word-fall-through register FIFO absorbing words popped from the BRAM FIFO.
// The head word and its valid flag are kept in registers so the stream outputs are glitch-free.
module reader_skid_fifo
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_READ_LATENCY + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         head_data_o,
  output logic                          head_valid_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  valid_q, valid_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Look ahead through this cycle's push so a word landing in an empty buffer shows next edge.
    head_d  = mem_d[rd_ptr_d];
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  // Storage needs no reset: contents are only observed through count/valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_data_o  = head_q;
  assign head_valid_o = valid_q;
  assign count_o      = count_q;

endmodule

// File: rtl/bram_fifo_reader.sv
// Read-side adapter for bram_fifo: issues pops against buffer credit, tracks words in flight
// through the FIFO read latency and presents them as a bubble-free valid/ready stream.
module bram_fifo_reader
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter int unsigned SKID_DEPTH   = READ_LATENCY + 1
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [DATA_WIDTH-1:0]              FIFO_DOUT,
  input  logic                               FIFO_EMPTY,
  input  logic                               FIFO_ALMOST_EMPTY,
  output logic                               FIFO_RD_EN,
  output logic [DATA_WIDTH-1:0]              M_DATA,
  output logic                               M_VALID,
  input  logic                               M_READY,
  output logic [$clog2(SKID_DEPTH+1)-1:0]    OCCUPANCY
);

  localparam int unsigned CW = cnt_width(SKID_DEPTH);
  localparam int unsigned SW = CW + 1;

  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           occ;
  logic [SW-1:0]           credit_used_c;
  logic                    rd_en_c;
  logic                    capture_c;
  logic                    xfer_c;
  logic                    skid_valid;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic                    almost_empty_unused;

  assign almost_empty_unused = FIFO_ALMOST_EMPTY;

  assign xfer_c    = skid_valid && M_READY;
  assign capture_c = rd_pipe_q[READ_LATENCY-1];

  // A transfer this cycle frees its slot immediately, keeping full throughput at SKID_DEPTH = RL+1.
  always_comb begin
    credit_used_c = SW'(inflight_q) + SW'(occ) - SW'(xfer_c);
    rd_en_c       = !RESET && !FIFO_EMPTY && (credit_used_c < SW'(SKID_DEPTH));
  end

  always_comb begin
    rd_pipe_d  = (rd_pipe_q << 1) | READ_LATENCY'(rd_en_c);
    inflight_d = inflight_q;
    case ({rd_en_c, capture_c})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_pipe_q  <= '0;
      inflight_q <= '0;
    end else begin
      rd_pipe_q  <= rd_pipe_d;
      inflight_q <= inflight_d;
    end
  end

  reader_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .push_i       (capture_c),
    .push_data_i  (FIFO_DOUT),
    .pop_i        (xfer_c),
    .head_data_o  (skid_data),
    .head_valid_o (skid_valid),
    .count_o      (occ)
  );

  assign FIFO_RD_EN = rd_en_c;
  assign M_DATA     = skid_data;
  assign M_VALID    = skid_valid;
  assign OCCUPANCY  = occ;

  a_credit_bound: assert property (@(posedge CLK) disable iff (RESET)
    (SW'(inflight_q) + SW'(occ)) <= SW'(SKID_DEPTH));

  // Covers the capture-plus-transfer-at-full case too: the credit rule must keep a slot free.
  a_no_overrun: assert property (@(posedge CLK) disable iff (RESET)
    capture_c |-> (occ < CW'(SKID_DEPTH)));

  a_no_empty_pop: assert property (@(posedge CLK)
    FIFO_RD_EN |-> !FIFO_EMPTY);

endmodule

// File: tb/tb_bram_fifo_reader.sv
// Bench for bram_fifo_reader: a queue-based BRAM FIFO model (READ_LATENCY=2) drives the DUT,
// and a word-level model of the stream checks every cycle.
module tb_bram_fifo_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned RL = 2;
  localparam int unsigned SD = RL + 1;
  localparam int unsigned OW = $clog2(SD + 1);

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [DW-1:0] FIFO_DOUT = '0;
  logic          FIFO_EMPTY = 1'b1;
  logic          FIFO_ALMOST_EMPTY = 1'b1;
  logic          FIFO_RD_EN;
  logic [DW-1:0] M_DATA;
  logic          M_VALID;
  logic          M_READY = 1'b0;
  logic [OW-1:0] OCCUPANCY;

  always #5 CLK = ~CLK;

  bram_fifo_reader #(
    .DATA_WIDTH   (DW),
    .READ_LATENCY (RL),
    .SKID_DEPTH   (SD)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .FIFO_DOUT         (FIFO_DOUT),
    .FIFO_EMPTY        (FIFO_EMPTY),
    .FIFO_ALMOST_EMPTY (FIFO_ALMOST_EMPTY),
    .FIFO_RD_EN        (FIFO_RD_EN),
    .M_DATA            (M_DATA),
    .M_VALID           (M_VALID),
    .M_READY           (M_READY),
    .OCCUPANCY         (OCCUPANCY)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- BRAM FIFO model and stream model ----------------
  logic [DW-1:0] fq[$];        // words inside the FIFO
  logic [DW-1:0] exp_q[$];     // words the stream still owes, in order
  longint        arr_q[$];     // edge at which each popped word lands in the buffer
  int            occ_m = 0;
  longint        cyc = 0;
  logic [DW-1:0] due_word [8];
  bit            due_vld [8];
  bit            wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  bit            rd_en_s = 1'b0;
  bit            xfer_pend = 1'b0;
  int            reset_edges = 0;
  int            bad_pop = 0;

  always @(posedge CLK) begin
    cyc++;
    if (RESET) begin
      fq.delete();
      exp_q.delete();
      arr_q.delete();
      occ_m = 0;
      for (int i = 0; i < 8; i++) due_vld[i] = 1'b0;
      reset_edges++;
      FIFO_EMPTY        <= 1'b1;
      FIFO_ALMOST_EMPTY <= 1'b1;
      FIFO_DOUT         <= '0;
    end else begin
      reset_edges = 0;
      // DOUT shows a popped word READ_LATENCY-1 edges after the pop; junk otherwise
      if (due_vld[int'(cyc % 8)]) begin
        FIFO_DOUT <= due_word[int'(cyc % 8)];
        due_vld[int'(cyc % 8)] = 1'b0;
      end else begin
        FIFO_DOUT <= DW'($urandom);
      end
      if (arr_q.size() != 0 && arr_q[0] == cyc) begin
        void'(arr_q.pop_front());
        occ_m++;
      end
      if (xfer_pend) occ_m--;
      if (rd_en_s) begin
        if (fq.size() == 0) bad_pop++;
        else begin
          due_word[int'((cyc + RL - 1) % 8)] = fq.pop_front();
          due_vld[int'((cyc + RL - 1) % 8)]  = 1'b1;
          arr_q.push_back(cyc + RL);
        end
      end
      if (wr_en) begin
        fq.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
      FIFO_EMPTY        <= (fq.size() == 0);
      FIFO_ALMOST_EMPTY <= (fq.size() <= 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  longint        ncyc = 0;
  int            rd_cnt, vld_cnt, xfer_cnt;
  longint        first_rd, first_v, first_x, last_x;
  logic [DW-1:0] first_data, last_data;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  task automatic clear_stats();
    rd_cnt = 0; vld_cnt = 0; xfer_cnt = 0;
    first_rd = -1; first_v = -1; first_x = -1; last_x = -1;
    first_data = '0; last_data = '0;
  endtask

  always @(negedge CLK) begin
    bit exp_rd;
    rd_en_s   = FIFO_RD_EN;
    xfer_pend = M_VALID && M_READY;
    ncyc++;
    if (RESET) begin
      chk("rd_en_in_reset", FIFO_RD_EN, 0);
      if (reset_edges > 0) begin
        chk("valid_in_reset", M_VALID, 0);
        chk("occ_in_reset", OCCUPANCY, 0);
        chk("data_in_reset", M_DATA, 0);
      end
    end else begin
      exp_rd = !FIFO_EMPTY && ((arr_q.size() + occ_m - (xfer_pend ? 1 : 0)) < int'(SD));
      chk("rd_en", FIFO_RD_EN, exp_rd);
      chk("occupancy", OCCUPANCY, occ_m);
      chk("m_valid", M_VALID, occ_m != 0);
      chk("credit_bound", (arr_q.size() + occ_m <= int'(SD)), 1);
      if (M_VALID) begin
        if (exp_q.size() == 0) chk("m_data_unowed", 1, 0);
        else chk("m_data", M_DATA, exp_q[0]);
      end
      if (stall_prev) begin
        chk("stall_valid", M_VALID, 1);
        chk("stall_data", M_DATA, data_prev);
      end
      if (FIFO_RD_EN) begin
        if (first_rd < 0) first_rd = ncyc;
        rd_cnt++;
      end
      if (M_VALID) begin
        if (first_v < 0) first_v = ncyc;
        vld_cnt++;
      end
      if (xfer_pend) begin
        if (xfer_cnt == 0) begin
          first_x    = ncyc;
          first_data = M_DATA;
        end
        last_x    = ncyc;
        last_data = M_DATA;
        xfer_cnt++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    stall_prev = !RESET && M_VALID && !M_READY;
    data_prev  = M_DATA;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    wr_en = 1'b0;
    repeat (n) step();
    RESET = 1'b0;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(DW'(i));
      exp_q.push_back(DW'(i));
    end
  endtask

  task automatic wait_xfers(input string name, input int target, input int budget);
    int k = 0;
    while (xfer_cnt < target && k < budget) begin
      step();
      k++;
    end
    chk(name, xfer_cnt, target);
  endtask

  initial begin
    int next;
    int k;
    clear_stats();
    repeat (3) step();
    @(negedge CLK);
    chk("rst_rd_en", FIFO_RD_EN, 0);
    chk("rst_valid", M_VALID, 0);
    chk("rst_data", M_DATA, 0);
    chk("rst_occ", OCCUPANCY, 0);
    step();
    RESET = 1'b0;

    // continuous drain
    clear_stats();
    preload(256);
    M_READY = 1'b1;
    wait_xfers("drain_count", 256, 400);
    repeat (4) step();
    // issue seen at negedge k -> issuing edge k+1 -> valid after edge k+3 -> seen at negedge k+3
    chk("drain_first_latency", first_v - first_rd, 3);
    chk("drain_no_gap", last_x - first_x, 255);
    chk("drain_first_word", first_data, 0);
    chk("drain_last_word", last_data, 255);
    chk("drain_pops", rd_cnt, 256);
    chk("drain_empty", FIFO_EMPTY, 1);
    chk("drain_occ", OCCUPANCY, 0);

    // empty FIFO
    do_reset(3);
    clear_stats();
    M_READY = 1'b1;
    repeat (300) step();
    chk("empty_no_pop", rd_cnt, 0);
    chk("empty_no_valid", vld_cnt, 0);

    // backpressure
    do_reset(3);
    clear_stats();
    preload(256);
    M_READY = 1'b0;
    repeat (20) step();
    chk("bp_pops", rd_cnt, 3);
    chk("bp_occ", OCCUPANCY, 3);
    chk("bp_valid", M_VALID, 1);
    chk("bp_data", M_DATA, 0);
    clear_stats();
    M_READY = 1'b1;
    wait_xfers("bp_count", 256, 400);
    chk("bp_no_gap", last_x - first_x, 255);
    chk("bp_first_word", first_data, 0);
    chk("bp_last_word", last_data, 255);

    // random ready with concurrent writes
    do_reset(3);
    clear_stats();
    next = 0;
    k = 0;
    while (xfer_cnt < 400 && k < 6000) begin
      M_READY = ($urandom_range(0, 99) < 30);
      if (next < 400 && $urandom_range(0, 1) == 1) begin
        wr_en   = 1'b1;
        wr_data = DW'(next);
        next++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      k++;
    end
    wr_en = 1'b0;
    chk("rand_count", xfer_cnt, 400);
    chk("rand_first_word", first_data, 0);
    chk("rand_last_word", last_data, 399);
    chk("rand_owed", exp_q.size(), 0);

    // reset mid-stream
    do_reset(3);
    clear_stats();
    preload(256);
    M_READY = 1'b1;
    wait_xfers("mid_reach", 100, 200);
    chk("mid_inflight", arr_q.size(), 2);
    chk("mid_occ", OCCUPANCY, 1);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_rst_rd_en", FIFO_RD_EN, 0);
    chk("mid_rst_valid", M_VALID, 0);
    chk("mid_rst_occ", OCCUPANCY, 0);
    chk("mid_rst_data", M_DATA, 0);
    repeat (4) @(posedge CLK);
    #1;
    RESET = 1'b0;
    clear_stats();
    preload(10);
    repeat (30) step();
    chk("refill_count", xfer_cnt, 10);
    chk("refill_first", first_data, 0);
    chk("refill_last", last_data, 9);
    chk("refill_owed", exp_q.size(), 0);

    chk("no_pop_while_empty", bad_pop, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
